// File: rtl/fp_cvt_pkg.sv
// fp_cvt shared types and constants.
// FSM state encoding, exponent limits, saturation values.
package fp_cvt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ROUND
  } state_t;

  localparam logic OP_I2F = 1'b0;
  localparam logic OP_F2I = 1'b1;

  localparam logic [7:0] EXP_BIAS    = 8'd127;
  localparam logic [7:0] EXP_INT_MAX = 8'd158;
  localparam logic [7:0] EXP_INF     = 8'd255;

  localparam logic [31:0] SAT_S_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_S_MIN = 32'h8000_0000;
  localparam logic [31:0] SAT_U_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/fp_cvt_round.sv
// Round-to-nearest-even increment for a 24-bit significand.
// In: mant, guard, sticky. Out: mant_rnd, carry (significand overflow).
module fp_cvt_round (
  input  logic [23:0] mant,
  input  logic        guard,
  input  logic        sticky,
  output logic [23:0] mant_rnd,
  output logic        carry
);

  logic inc;

  // Ties go up only when the kept lsb is odd.
  assign inc = guard & (sticky | mant[0]);

  assign {carry, mant_rnd} = {1'b0, mant} + {24'd0, inc};

endmodule

// File: rtl/fp_cvt.sv
// Multi-cycle int32 <-> float32 converter, one shift per cycle.
// Ports: clk, rst_n, start, op, is_unsigned, src -> busy, done, result, nv, nx.
// FP_CVT_UNSIGNED_EN enables the is_unsigned integer mode.
module fp_cvt
  import fp_cvt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic        is_unsigned,
  input  logic [31:0] src,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        nv,
  output logic        nx
);

  state_t state_q;
  state_t state_d;

  logic        op_q;
  logic        sign_q;
  logic [31:0] mant_q;
  logic [7:0]  exp_q;
  logic [4:0]  cnt_q;
  logic        sticky_q;
  logic        spec_q;
  logic [31:0] spec_res_q;
  logic        spec_nv_q;
  logic        spec_nx_q;

  logic        uns;
  logic [31:0] pos_sat;
  logic        pos_ovf;

  logic        f_sign;
  logic [7:0]  f_exp;
  logic [22:0] f_frac;
  logic        f_nan;

  logic        cap_sign;
  logic [31:0] cap_mant;
  logic [4:0]  cap_cnt;
  logic        cap_n0;
  logic        cap_spec;
  logic [31:0] cap_res;
  logic        cap_nv;
  logic        cap_nx;

  logic        shift_last;

  logic [23:0] rnd_mant;
  logic        rnd_carry;
  logic        unused_hidden;
  logic [31:0] rnd_res;
  logic        rnd_nv;
  logic        rnd_nx;

  assign f_sign = src[31];
  assign f_exp  = src[30:23];
  assign f_frac = src[22:0];
  assign f_nan  = (f_exp == EXP_INF) && (f_frac != 23'd0);

`ifdef FP_CVT_UNSIGNED_EN
  assign uns     = is_unsigned;
  assign pos_sat = uns ? SAT_U_MAX : SAT_S_MAX;
  assign pos_ovf = uns ? (f_exp > EXP_INT_MAX)
                       : (f_exp >= EXP_INT_MAX);
`else
  logic unused_uns;
  assign unused_uns = is_unsigned;
  assign uns        = 1'b0;
  assign pos_sat    = SAT_S_MAX;
  assign pos_ovf    = (f_exp >= EXP_INT_MAX);
`endif

  // Operand unpack and early classification at the accepting edge.
  always_comb begin
    cap_sign = 1'b0;
    cap_mant = '0;
    cap_cnt  = '0;
    cap_n0   = 1'b0;
    cap_spec = 1'b0;
    cap_res  = '0;
    cap_nv   = 1'b0;
    cap_nx   = 1'b0;
    if (op == OP_I2F) begin
      cap_sign = ~uns & src[31];
      cap_mant = cap_sign ? (~src + 32'd1) : src;
      cap_n0   = cap_mant[31] | ~|cap_mant;
    end else begin
      cap_sign = f_sign;
      cap_mant = {1'b1, f_frac, 8'd0};
      cap_cnt  = 5'(EXP_INT_MAX - f_exp);
      if (f_nan) begin
        cap_spec = 1'b1;
        cap_res  = pos_sat;
        cap_nv   = 1'b1;
      end else if (f_exp < EXP_BIAS) begin
        cap_spec = 1'b1;
        cap_nx   = |src[30:0];
      end else if (!f_sign) begin
        if (pos_ovf) begin
          cap_spec = 1'b1;
          cap_res  = pos_sat;
          cap_nv   = 1'b1;
        end
      end else if (uns) begin
        cap_spec = 1'b1;
        cap_nv   = 1'b1;
      end else if ((f_exp > EXP_INT_MAX) ||
                   ((f_exp == EXP_INT_MAX) && (f_frac != 23'd0))) begin
        cap_spec = 1'b1;
        cap_res  = SAT_S_MIN;
        cap_nv   = 1'b1;
      end
      // -2^31 and unsigned 2^31 need no shifting.
      cap_n0 = cap_spec | (f_exp == EXP_INT_MAX);
    end
  end

  // I2F stops once the shifted-in msb is one; F2I counts down.
  assign shift_last = (op_q == OP_I2F) ? mant_q[30]
                                       : (cnt_q == 5'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = cap_n0 ? ST_ROUND : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_last) state_d = ST_ROUND;
      end
      ST_ROUND: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  fp_cvt_round u_round (
    .mant     (mant_q[31:8]),
    .guard    (mant_q[7]),
    .sticky   (|mant_q[6:0]),
    .mant_rnd (rnd_mant),
    .carry    (rnd_carry)
  );

  // Hidden bit is implied by the exponent, not stored.
  assign unused_hidden = rnd_mant[23];

  always_comb begin
    rnd_res = '0;
    rnd_nv  = 1'b0;
    rnd_nx  = 1'b0;
    if (op_q == OP_I2F) begin
      rnd_nx = mant_q[7] | |mant_q[6:0];
      if (|mant_q)
        rnd_res = {sign_q, exp_q + {7'd0, rnd_carry}, rnd_mant[22:0]};
    end else if (spec_q) begin
      rnd_res = spec_res_q;
      rnd_nv  = spec_nv_q;
      rnd_nx  = spec_nx_q;
    end else begin
      rnd_res = sign_q ? (~mant_q + 32'd1) : mant_q;
      rnd_nx  = sticky_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_I2F;
      sign_q     <= 1'b0;
      mant_q     <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_nv_q  <= 1'b0;
      spec_nx_q  <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      nv         <= 1'b0;
      nx         <= 1'b0;
    end else begin
      done <= (state_q == ST_ROUND);
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q       <= op;
            sign_q     <= cap_sign;
            mant_q     <= cap_mant;
            exp_q      <= EXP_INT_MAX;
            cnt_q      <= cap_cnt;
            sticky_q   <= 1'b0;
            spec_q     <= cap_spec;
            spec_res_q <= cap_res;
            spec_nv_q  <= cap_nv;
            spec_nx_q  <= cap_nx;
          end
        end
        ST_SHIFT: begin
          if (op_q == OP_I2F) begin
            mant_q <= {mant_q[30:0], 1'b0};
            exp_q  <= exp_q - 8'd1;
          end else begin
            mant_q   <= {1'b0, mant_q[31:1]};
            sticky_q <= sticky_q | mant_q[0];
            cnt_q    <= cnt_q - 5'd1;
          end
        end
        ST_ROUND: begin
          result <= rnd_res;
          nv     <= rnd_nv;
          nx     <= rnd_nx;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_cvt.sv
// Directed testbench for fp_cvt.
// Checks reset, I2F, F2I, mid-op reset and back-to-back starts.
module tb_fp_cvt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        is_unsigned = 1'b0;
  logic [31:0] src = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        nv;
  logic        nx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_cvt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .is_unsigned (is_unsigned),
    .src         (src),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .nv          (nv),
    .nx          (nx)
  );

`ifdef FP_CVT_UNSIGNED_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif

  localparam int NI = 10;
  localparam bit [31:0] I_SRC [NI] = '{
    32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000,
    32'hFFFF_FFFF, 32'h0100_0001, 32'h0100_0003, 32'h0000_0003,
    32'h8000_0000, 32'hFFFF_FFFF};
  localparam bit I_UNS [NI] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  localparam bit [31:0] I_RES [NI] = '{
    32'h3F80_0000, 32'h4F00_0000, 32'hCF00_0000, 32'h0000_0000,
    32'hBF80_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4040_0000,
    UEN ? 32'h4F00_0000 : 32'hCF00_0000,
    UEN ? 32'h4F80_0000 : 32'hBF80_0000};
  localparam bit I_NX [NI] = '{0, 1, 0, 0, 0, 1, 1, 0, 0, UEN};
  localparam int I_LAT [NI] = '{
    33, 3, 2, 2, 33, 9, 9, 32, 2, UEN ? 2 : 33};

  localparam int NF = 17;
  localparam bit [31:0] F_SRC [NF] = '{
    32'hC049_0FDB, 32'h4F00_0000, 32'h7FC0_0000, 32'hCF00_0000,
    32'hCF00_0001, 32'hFF80_0000, 32'h7F80_0000, 32'h3F00_0000,
    32'h8000_0000, 32'h3F80_0000, 32'h42F6_0000, 32'hBFC0_0000,
    32'h4F00_0000, 32'hBF80_0000, 32'h4F80_0000, 32'hBF00_0000,
    32'h4EFF_FFFF};
  localparam bit F_UNS [NF] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
  localparam bit [31:0] F_RES [NF] = '{
    32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
    32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0001, 32'h0000_007B, 32'hFFFF_FFFF,
    UEN ? 32'h8000_0000 : 32'h7FFF_FFFF,
    UEN ? 32'h0000_0000 : 32'hFFFF_FFFF,
    UEN ? 32'hFFFF_FFFF : 32'h7FFF_FFFF,
    32'h0000_0000, 32'h7FFF_FF80};
  localparam bit F_NV [NF] = '{
    0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, !UEN, UEN, 1, 0, 0};
  localparam bit F_NX [NF] = '{
    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
  localparam int F_LAT [NF] = '{
    32, 2, 2, 2, 2, 2, 2, 2, 2, 33, 27, 33, 2,
    UEN ? 2 : 33, 2, 2, 3};

  // Latency counts edges from the edge start is driven after.
  task automatic do_op(input logic o, input logic u,
                       input logic [31:0] s,
                       output logic [31:0] r, output logic v,
                       output logic x, output int lat);
    @(posedge clk); #1;
    op = o;
    is_unsigned = u;
    src = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src = $urandom;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    v = nv;
    x = nx;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL rst_done got %b want 0", done);
    end
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL rst_result got %h want 0", result);
    end
    checks++;
    if ({nv, nx} !== 2'b00) begin
      failures++;
      $display("FAIL rst_flags got %b%b want 00", nv, nx);
    end
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_i2f;
    logic [31:0] r;
    logic v, x;
    int lat;
    for (int i = 0; i < NI; i++) begin
      do_op(1'b0, I_UNS[i], I_SRC[i], r, v, x, lat);
      checks++;
      if (r !== I_RES[i]) begin
        failures++;
        $display("FAIL i2f[%0d] result got %h want %h",
                 i, r, I_RES[i]);
      end
      checks++;
      if ({v, x} !== {1'b0, I_NX[i]}) begin
        failures++;
        $display("FAIL i2f[%0d] nv/nx got %b%b want 0%b",
                 i, v, x, I_NX[i]);
      end
      checks++;
      if (lat != I_LAT[i]) begin
        failures++;
        $display("FAIL i2f[%0d] latency got %0d want %0d",
                 i, lat, I_LAT[i]);
      end
    end
  endtask

  task automatic test_f2i;
    logic [31:0] r;
    logic v, x;
    int lat;
    for (int i = 0; i < NF; i++) begin
      do_op(1'b1, F_UNS[i], F_SRC[i], r, v, x, lat);
      checks++;
      if (r !== F_RES[i]) begin
        failures++;
        $display("FAIL f2i[%0d] result got %h want %h",
                 i, r, F_RES[i]);
      end
      checks++;
      if ({v, x} !== {F_NV[i], F_NX[i]}) begin
        failures++;
        $display("FAIL f2i[%0d] nv/nx got %b%b want %b%b",
                 i, v, x, F_NV[i], F_NX[i]);
      end
      checks++;
      if (lat != F_LAT[i]) begin
        failures++;
        $display("FAIL f2i[%0d] latency got %0d want %0d",
                 i, lat, F_LAT[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    logic v, x;
    int lat;
    int ndone;
    int nbusy;
    @(posedge clk); #1;
    op = 1'b0;
    is_unsigned = 1'b0;
    src = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, nv, nx} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_rst ctl got %b%b%b%b want 0000",
               busy, done, nv, nx);
    end
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst result got %h want 0", result);
    end
    #3;
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    checks++;
    if (ndone != 0 || nbusy != 0) begin
      failures++;
      $display("FAIL mid_rst stale done=%0d busy=%0d want 0 0",
               ndone, nbusy);
    end
    do_op(1'b0, 1'b0, 32'h7FFF_FFFF, r, v, x, lat);
    checks++;
    if (r !== 32'h4F00_0000 || lat != 3) begin
      failures++;
      $display("FAIL mid_rst next got %h lat %0d want 4f000000 lat 3",
               r, lat);
    end
  endtask

  task automatic test_back_to_back;
    int ndone;
    logic exp_b;
    logic exp_d;
    ndone = 0;
    @(posedge clk); #1;
    op = 1'b0;
    is_unsigned = 1'b0;
    src = 32'h7FFF_FFFF;
    start = 1'b1;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(posedge clk); #1;
      exp_d = (cyc % 3 == 0);
      exp_b = !exp_d;
      checks++;
      if (busy !== exp_b || done !== exp_d) begin
        failures++;
        $display("FAIL b2b cyc%0d busy/done got %b%b want %b%b",
                 cyc, busy, done, exp_b, exp_d);
      end
      if (done) begin
        ndone++;
        checks++;
        if (result !== 32'h4F00_0000) begin
          failures++;
          $display("FAIL b2b cyc%0d result got %h want 4f000000",
                   cyc, result);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 7) begin
      failures++;
      $display("FAIL b2b done_count got %0d want 7", ndone);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_i2f;
    test_f2i;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_cvt.md
FP_CVT -- requirements
Module: fp_cvt

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have: op  input  1  0 = int32->float32 (I2F), 1 = float32->int32 (F2I).
REQ-005 SHALL have: is_unsigned  input  1  treat the integer side as unsigned.
REQ-006 SHALL have: src  input  32  operand, captured on the accepting edge.
REQ-007 SHALL have: busy  output  1  high whenever state != IDLE.
REQ-008 SHALL have: done  output  1  one-cycle pulse; result/flags valid.
REQ-009 SHALL have: result  output  32  converted value, held until the next done.
REQ-010 SHALL have: nv, nx  output  1 each  invalid / inexact, held with result.

Function
REQ-011 FSM SHALL be IDLE -> SHIFT (N cycles, N >= 0) -> ROUND (1 cycle) -> IDLE, with done asserted during the first IDLE cycle after ROUND; N = 0 goes IDLE -> ROUND directly.
REQ-012 done SHALL rise N+2 edges after the edge that samples start.
REQ-013 start while busy SHALL be ignored; start in the same cycle as done SHALL be accepted.
REQ-014 I2F capture: mag = src, or -src if signed and src[31]; mant = mag; exp = 158; sign = signed & src[31].
REQ-015 I2F SHIFT: while mant[31] == 0, mant <<= 1 and exp -= 1, one bit per cycle; src == 0 gives N = 0 and result 0x00000000.
REQ-016 I2F ROUND: frac = mant[30:8], guard = mant[7], sticky = |mant[6:0]; round to nearest even; mantissa carry-out gives exp+1 and frac 0; nx = guard|sticky; nv = 0.
REQ-017 F2I rounding SHALL be round-toward-zero; unpack e = src[30:23]; mant = {1, src[22:0], 8'b0}; N = 158 - e for 127 <= e <= 158.
REQ-018 F2I SHIFT: mant >>= 1 per cycle; shifted-out ones OR into sticky; ROUND negates if sign; nx = sticky.
REQ-019 F2I with e < 127: N = 0; result 0; nx = (src[30:0] != 0).
REQ-020 F2I NaN, +inf, or positive overflow (signed: e >= 158; unsigned: e >= 159): N = 0, nv = 1, result 0x7FFFFFFF (signed) or 0xFFFFFFFF (unsigned).
REQ-021 F2I -inf or negative overflow, signed: result 0x80000000, nv = 1; exactly -2^31 (0xCF000000) SHALL be valid, nv = 0.
REQ-022 F2I unsigned, negative with e >= 127: result 0, nv = 1, N = 0.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, busy = 0, done = 0, result = 0, nv = nx = 0, including mid-conversion; the in-flight operation is discarded with no done.
REQ-024 First start after rst_n deasserts SHALL be accepted on the next edge.

Configuration
REQ-025 Macro FP_CVT_UNSIGNED_EN defined: is_unsigned honoured per REQ-014 to REQ-022.
REQ-026 FP_CVT_UNSIGNED_EN undefined: is_unsigned ignored (treated as 0); unsigned saturation logic absent; port still present.

Structure
REQ-027 Package fp_cvt_pkg SHALL hold the state enum, EXP_BIAS = 127, EXP_INT_MAX = 158, and saturation constants (0x7FFFFFFF, 0x80000000, 0xFFFFFFFF).
REQ-028 RNE increment SHALL live in combinational sub-module fp_cvt_round (in: 24-bit mantissa, guard, sticky; out: rounded mantissa, carry).

Verification
REQ-029 I2F signed src = 0x00000001 -> result 0x3F800000, nx = 0, done 33 cycles after start.
REQ-030 I2F signed src = 0x7FFFFFFF -> 0x4F000000, nx = 1, done at 3; src = 0x80000000 -> 0xCF000000, nx = 0, done at 2.
REQ-031 F2I signed src = 0xC0490FDB (-3.14159) -> 0xFFFFFFFD, nx = 1, done at 32.
REQ-032 F2I src = 0x4F000000: signed -> 0x7FFFFFFF, nv = 1; unsigned (macro on) -> 0x80000000, nv = 0; src = 0x7FC00000 signed -> 0x7FFFFFFF, nv = 1.
REQ-033 rst_n pulsed low at cycle 10 of a 33-cycle I2F -> outputs 0 at once, no done; new start afterwards completes normally.
REQ-034 start held high continuously -> back-to-back conversions, one done per operation, no start accepted while busy.
